// File: rtl/bft_pkt_pkg.sv
// BFT packet field geometry plus helpers to build a data packet and pull out its port field.
package bft_pkt_pkg;

  localparam int PACKET_BITS   = 97;
  localparam int NUM_LEAF_BITS = 6;
  localparam int NUM_PORT_BITS = 4;
  localparam int NUM_ADDR_BITS = 7;
  localparam int PAYLOAD_BITS  = 64;

  localparam int PAD_BITS    = PACKET_BITS - 1 - NUM_LEAF_BITS - NUM_PORT_BITS
                               - NUM_ADDR_BITS - PAYLOAD_BITS;
  localparam int PORT_MSB    = PACKET_BITS - 2 - NUM_LEAF_BITS;
  localparam int DEPTH       = 2 ** NUM_ADDR_BITS;
  localparam int CREDIT_BITS = NUM_ADDR_BITS + 1;

  typedef struct packed {
    logic                     vld;
    logic [NUM_LEAF_BITS-1:0] leaf;
    logic [NUM_PORT_BITS-1:0] port;
    logic [PAD_BITS-1:0]      pad;
    logic [NUM_ADDR_BITS-1:0] addr;
    logic [PAYLOAD_BITS-1:0]  payload;
  } pkt_t;

  function automatic logic [PACKET_BITS-1:0] build_pkt(
    input logic [NUM_LEAF_BITS-1:0] leaf,
    input logic [NUM_PORT_BITS-1:0] port,
    input logic [NUM_ADDR_BITS-1:0] addr,
    input logic [PAYLOAD_BITS-1:0]  payload
  );
    pkt_t p;
    p.vld     = 1'b1;
    p.leaf    = leaf;
    p.port    = port;
    p.pad     = '0;
    p.addr    = addr;
    p.payload = payload;
    return p;
  endfunction

  function automatic logic [NUM_PORT_BITS-1:0] pkt_port(input logic [PACKET_BITS-1:0] pkt);
    return pkt[PORT_MSB -: NUM_PORT_BITS];
  endfunction

endpackage

// File: rtl/credit_counter.sv
// Sender-side credit pool: one credit per accepted beat, UPDATE_SIZE back per freespace update.
// Registered; sums above DEPTH clamp to DEPTH and latch a sticky overflow flag.
module credit_counter
  import bft_pkt_pkg::*;
#(
  parameter int UPDATE_SIZE = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   consume,
  input  logic                   replenish,
  output logic [CREDIT_BITS-1:0] credits,
  output logic                   nonzero,
  output logic                   overflow
);

  localparam int SUM_BITS = CREDIT_BITS + 1;

  logic [SUM_BITS-1:0] sum;

  // consume is only ever asserted with credits nonzero, so the subtraction cannot wrap
  always_comb begin
    sum = {1'b0, credits} - SUM_BITS'(consume)
          + (replenish ? SUM_BITS'(UPDATE_SIZE) : SUM_BITS'(0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      credits  <= CREDIT_BITS'(DEPTH);
      overflow <= 1'b0;
    end else if (sum > SUM_BITS'(DEPTH)) begin
      credits  <= CREDIT_BITS'(DEPTH);
      overflow <= 1'b1;
    end else begin
      credits  <= sum[CREDIT_BITS-1:0];
    end
  end

  assign nonzero = |credits;

endmodule

// File: rtl/output_port_credit.sv
// Leaf sender into the BFT: one packet/cycle, 1-cycle latency, holds output until ack; stalls at zero credits.
// Optional stall counter behind macro OUTPUT_PORT_STALL_CNT_EN.
module output_port_credit
  import bft_pkt_pkg::*;
#(
  parameter int PORT_No               = 2,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_LEAF_BITS-1:0] dst_leaf,
  input  logic [NUM_PORT_BITS-1:0] dst_port,
  input  logic [PAYLOAD_BITS-1:0]  din_user2interface,
  input  logic                     vld_user2interface,
  output logic                     ack_interface2user,
  output logic [PACKET_BITS-1:0]   dout_interface2bft,
  input  logic                     ack_bft2interface,
  input  logic [PACKET_BITS-1:0]   din_bft2interface,
  output logic                     credit_overflow
`ifdef OUTPUT_PORT_STALL_CNT_EN
  ,
  output logic [31:0]              stall_cnt
`endif
);

  logic [NUM_ADDR_BITS-1:0] addr;
  logic [PACKET_BITS-1:0]   out_q;
  logic [CREDIT_BITS-1:0]   credits;
  logic                     credits_nonzero;
  logic                     out_valid;
  logic                     out_ready;
  logic                     accept;
  logic                     update;
  logic                     unused_bft_bits;

  assign out_valid = out_q[PACKET_BITS-1];
  assign out_ready = ~out_valid | ack_bft2interface;
  assign accept    = vld_user2interface & credits_nonzero & out_ready;
  assign update    = din_bft2interface[PACKET_BITS-1]
                     & (pkt_port(din_bft2interface) == NUM_PORT_BITS'(PORT_No));

  assign ack_interface2user = accept;
  assign dout_interface2bft = out_q;
  assign unused_bft_bits    = ^din_bft2interface;

  credit_counter #(
    .UPDATE_SIZE (FREESPACE_UPDATE_SIZE)
  ) u_credit (
    .clk       (clk),
    .reset     (reset),
    .consume   (accept),
    .replenish (update),
    .credits   (credits),
    .nonzero   (credits_nonzero),
    .overflow  (credit_overflow)
  );

  // An ack with no new beat leaves an all-zero word so the link sees a clean idle
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
      addr  <= '0;
    end else if (accept) begin
      out_q <= build_pkt(dst_leaf, dst_port, addr, din_user2interface);
      addr  <= addr + 1'b1;
    end else if (ack_bft2interface) begin
      out_q <= '0;
    end
  end

`ifdef OUTPUT_PORT_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (vld_user2interface && !credits_nonzero && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_output_port_credit.sv
// Randomized scoreboard bench for output_port_credit against a queue/integer reference model.
module tb_output_port_credit;
  import bft_pkt_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  dst_leaf;
  logic [3:0]  dst_port;
  logic [63:0] din_user2interface;
  logic        vld_user2interface;
  logic        ack_interface2user;
  logic [96:0] dout_interface2bft;
  logic        ack_bft2interface;
  logic [96:0] din_bft2interface;
  logic        credit_overflow;
`ifdef OUTPUT_PORT_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  output_port_credit dut (
    .clk                (clk),
    .reset              (reset),
    .dst_leaf           (dst_leaf),
    .dst_port           (dst_port),
    .din_user2interface (din_user2interface),
    .vld_user2interface (vld_user2interface),
    .ack_interface2user (ack_interface2user),
    .dout_interface2bft (dout_interface2bft),
    .ack_bft2interface  (ack_bft2interface),
    .din_bft2interface  (din_bft2interface),
    .credit_overflow    (credit_overflow)
`ifdef OUTPUT_PORT_STALL_CNT_EN
    ,
    .stall_cnt          (stall_cnt)
`endif
  );

  int checks = 0;
  int passed = 0;

  // Reference model: credit pool as a plain integer, in-flight packets as a queue
  logic [96:0] exp_q[$];
  int          m_credits;
  int          m_addr;
  int          m_ovf;
  int          m_stall;
  bit          m_presented;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  function automatic logic [96:0] upd_pkt(input logic [3:0] port);
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return {1'b1, 6'($urandom), port, r[85:0]};
  endfunction

  function automatic logic [96:0] idle_bft();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return {1'b0, r};
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    reset              = 1'b1;
    vld_user2interface = 1'b0;
    ack_bft2interface  = 1'b0;
    din_bft2interface  = '0;
    @(posedge clk);
    #1;
    exp_q.delete();
    m_credits   = 128;
    m_addr      = 0;
    m_ovf       = 0;
    m_stall     = 0;
    m_presented = 1'b0;
    dst_leaf    = 6'($urandom);
    dst_port    = 4'($urandom);
  endtask

  task automatic drive_cycle(input bit v, input bit a, input logic [96:0] bft);
    bit acc;
    bit upd;
    @(negedge clk);
    reset              = 1'b0;
    vld_user2interface = v;
    ack_bft2interface  = a;
    din_bft2interface  = bft;
    din_user2interface = {$urandom, $urandom};
    #1;
    check("credits", dut.u_credit.credits, m_credits);
    check("credit_overflow", credit_overflow, m_ovf);
`ifdef OUTPUT_PORT_STALL_CNT_EN
    check("stall_cnt", stall_cnt, m_stall);
`endif
    acc = v && (m_credits > 0) && (!m_presented || a);
    check("ack_interface2user", ack_interface2user, acc);
    if (acc) begin
      exp_q.push_back({1'b1, dst_leaf, dst_port, 15'b0, 7'(m_addr), din_user2interface});
      m_addr = (m_addr + 1) % 128;
    end
    m_presented = acc ? 1'b1 : (a ? 1'b0 : m_presented);
    upd = bft[96] && (bft[89:86] == 4'd2);
    if (v && m_credits == 0) m_stall++;
    m_credits = m_credits - int'(acc) + (upd ? 64 : 0);
    if (m_credits > 128) begin
      m_credits = 128;
      m_ovf     = 1;
    end
  endtask

  // Monitor: whatever is presented must match the oldest outstanding packet
  always @(negedge clk) begin
    if (mon_en) begin
      #2;
      if (dout_interface2bft[96]) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_pkt: actual %h required none", dout_interface2bft);
        end else begin
          check("dout", dout_interface2bft, exp_q[0]);
          if (ack_bft2interface) void'(exp_q.pop_front());
        end
      end else begin
        check("dout_idle", dout_interface2bft, 0);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: actual timeout required completion");
    $display("%0d/%0d checks passed", passed, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    reset              = 1'b1;
    vld_user2interface = 1'b0;
    ack_bft2interface  = 1'b0;
    din_bft2interface  = '0;
    din_user2interface = '0;
    dst_leaf           = '0;
    dst_port           = '0;
    reset_dut();
    mon_en = 1'b1;

    // Full window drains credits to zero, then beats are held
    for (int i = 0; i < 128; i++) drive_cycle(1, 1, idle_bft());
    repeat (3) drive_cycle(1, 1, idle_bft());

    // One update reopens 64 beats; addr carries on after the wrap
    drive_cycle(0, 1, upd_pkt(4'd2));
    for (int i = 0; i < 64; i++) drive_cycle(1, 1, idle_bft());
    repeat (2) drive_cycle(1, 1, idle_bft());

    // Down to one credit, then accept and update together
    drive_cycle(0, 1, upd_pkt(4'd2));
    for (int i = 0; i < 63; i++) drive_cycle(1, 1, idle_bft());
    drive_cycle(1, 1, upd_pkt(4'd2));

    // Output held for 5 cycles without ack
    drive_cycle(1, 1, idle_bft());
    repeat (5) drive_cycle(1, 0, idle_bft());
    drive_cycle(1, 1, idle_bft());
    repeat (2) drive_cycle(0, 1, idle_bft());

    // Update at full credits overflows, sticky until reset
    reset_dut();
    drive_cycle(0, 1, upd_pkt(4'd2));
    repeat (4) drive_cycle(0, 0, idle_bft());
    reset_dut();
    drive_cycle(0, 0, idle_bft());

    // Update addressed to another port is ignored
    for (int i = 0; i < 10; i++) drive_cycle(1, 1, idle_bft());
    drive_cycle(0, 1, upd_pkt(4'd3));
    repeat (2) drive_cycle(0, 1, idle_bft());

    // Reset with a packet presented drops it
    drive_cycle(1, 0, idle_bft());
    drive_cycle(0, 0, idle_bft());
    reset_dut();
    drive_cycle(1, 1, idle_bft());
    drive_cycle(0, 1, idle_bft());

    // Stall counting at zero credits
    for (int i = 0; i < 128; i++) drive_cycle(1, 1, idle_bft());
    repeat (10) drive_cycle(1, 1, idle_bft());
    drive_cycle(0, 1, idle_bft());

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      logic [96:0] bft;
      bit v, a;
      v = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 119) == 0) bft = upd_pkt($urandom_range(0, 1) != 0 ? 4'd2 : 4'd3);
      else bft = idle_bft();
      drive_cycle(v, a, bft);
    end

    repeat (4) drive_cycle(0, 1, idle_bft());
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
